// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers, read-mode enum and parameter checks for fifo_flex.
package fifo_pkg;
   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic bit params_ok(input int depth, input int af, input int ae);
      return depth >= 2 && (depth & (depth - 1)) == 0 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: single write port storage with asynchronous read.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO with standard/FWFT read, programmable
// almost flags, occupancy count, synchronous flush and sticky error flags.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int FWFT = 0,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     din,
   input  logic                      write,
   output logic                      full,
   output logic                      almost_full,
   output logic [DATA_WIDTH-1:0]     dout,
   input  logic                      read,
   output logic                      empty,
   output logic                      almost_empty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   input  logic                      flush,
   output logic                      overflow,
   output logic                      underflow
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam int CW = cnt_w(DEPTH);
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("fifo_flex: DEPTH must be a power of two >= 2 and thresholds in range");
   end

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt_next;
   logic [DATA_WIDTH-1:0] rdata, dout_q;
   logic wr_acc, rd_acc;

   fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .we(wr_acc),
      .waddr(wr_ptr[AW-1:0]),
      .wdata(din),
      .raddr(rd_ptr[AW-1:0]),
      .rdata(rdata)
   );

   // Accepts use the registered flags; flush masks both sides.
   always_comb begin
      wr_acc = write && !full && !flush;
      rd_acc = read && !empty && !flush;
      cnt_next = flush ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         dout_q <= '0;
         overflow <= 1'b0;
         underflow <= 1'b0;
         empty <= 1'b1;
         full <= 1'b0;
         almost_full <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr <= flush ? '0 : wr_ptr + PW'(wr_acc);
         rd_ptr <= flush ? '0 : rd_ptr + PW'(rd_acc);
         count <= cnt_next;
         empty <= cnt_next == '0;
         full <= cnt_next == CW'(DEPTH);
         almost_full <= cnt_next >= CW'(AF_THRESH);
         almost_empty <= cnt_next <= CW'(AE_THRESH);
         overflow <= !flush && (overflow || (write && full));
         underflow <= !flush && (underflow || (read && empty));
         dout_q <= (flush || MODE == FIFO_FWFT) ? '0 : rd_acc ? rdata : dout_q;
      end
   end

   assign dout = (MODE == FIFO_FWFT) ? (empty ? '0 : rdata) : dout_q;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: vector table, directed corner sequences and a queue-model random run
// for a standard-mode and a FWFT-mode fifo_flex instance.
module tb_fifo_flex;
   logic clk = 0, rst = 0;
   logic w0 = 0, r0 = 0, f0 = 0, w1 = 0, r1 = 0, f1 = 0;
   logic [7:0] din0 = 0, din1 = 0, dout0, dout1;
   logic full0, af0, emp0, ae0, ov0, un0, full1, af1, emp1, ae1, ov1, un1;
   logic [2:0] cnt0, cnt1;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) d0 (
      .clk(clk), .rst(rst), .din(din0), .write(w0), .full(full0), .almost_full(af0),
      .dout(dout0), .read(r0), .empty(emp0), .almost_empty(ae0), .count(cnt0),
      .flush(f0), .overflow(ov0), .underflow(un0)
   );
   fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) d1 (
      .clk(clk), .rst(rst), .din(din1), .write(w1), .full(full1), .almost_full(af1),
      .dout(dout1), .read(r1), .empty(emp1), .almost_empty(ae1), .count(cnt1),
      .flush(f1), .overflow(ov1), .underflow(un1)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] din;
      int cnt;
      logic [1:0] err;
      logic [7:0] dout;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic [2:0] op, input logic [7:0] d, input int c, input logic [1:0] e, input logic [7:0] o);
      tv.push_back('{op, d, c, e, o});
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Flags follow from the expected occupancy: DEPTH=4, AF_THRESH=3, AE_THRESH=1.
   task automatic chk_all(input string tag, input logic [2:0] a_cnt, input logic a_emp, input logic a_ful,
                          input logic a_af, input logic a_ae, input logic a_ov, input logic a_un,
                          input logic [7:0] a_dout, input int e_cnt, input logic e_ov, input logic e_un,
                          input logic [7:0] e_dout);
      chk({tag, " count"}, 32'(a_cnt), 32'(e_cnt));
      chk({tag, " empty"}, 32'(a_emp), 32'(e_cnt == 0));
      chk({tag, " full"}, 32'(a_ful), 32'(e_cnt == 4));
      chk({tag, " almost_full"}, 32'(a_af), 32'(e_cnt >= 3));
      chk({tag, " almost_empty"}, 32'(a_ae), 32'(e_cnt <= 1));
      chk({tag, " overflow"}, 32'(a_ov), 32'(e_ov));
      chk({tag, " underflow"}, 32'(a_un), 32'(e_un));
      chk({tag, " dout"}, 32'(a_dout), 32'(e_dout));
   endtask

   task automatic c0(input string tag, input int c, input logic ov, input logic un, input logic [7:0] d);
      chk_all({"std ", tag}, cnt0, emp0, full0, af0, ae0, ov0, un0, dout0, c, ov, un, d);
   endtask

   task automatic c1(input string tag, input int c, input logic ov, input logic un, input logic [7:0] d);
      chk_all({"fwft ", tag}, cnt1, emp1, full1, af1, ae1, ov1, un1, dout1, c, ov, un, d);
   endtask

   logic [7:0] q[$];
   logic [7:0] dstd;
   logic m_ov, m_un;

   initial begin
      // op = {write, read, flush}, err = {overflow, underflow}
      add(3'b100, 8'h11, 1, 2'b00, 8'h00);
      add(3'b100, 8'h22, 2, 2'b00, 8'h00);
      add(3'b100, 8'h33, 3, 2'b00, 8'h00);
      add(3'b100, 8'h44, 4, 2'b00, 8'h00);
      add(3'b010, 8'h00, 3, 2'b00, 8'h11);
      add(3'b010, 8'h00, 2, 2'b00, 8'h22);
      add(3'b100, 8'h55, 3, 2'b00, 8'h22);
      add(3'b100, 8'h66, 4, 2'b00, 8'h22);
      add(3'b010, 8'h00, 3, 2'b00, 8'h33);
      add(3'b010, 8'h00, 2, 2'b00, 8'h44);
      add(3'b110, 8'h77, 2, 2'b00, 8'h55);
      add(3'b010, 8'h00, 1, 2'b00, 8'h66);
      add(3'b010, 8'h00, 0, 2'b00, 8'h77);
      add(3'b110, 8'h88, 1, 2'b01, 8'h77);
      add(3'b010, 8'h00, 0, 2'b01, 8'h88);
      add(3'b001, 8'h00, 0, 2'b00, 8'h00);
      add(3'b100, 8'h01, 1, 2'b00, 8'h00);
      add(3'b100, 8'h02, 2, 2'b00, 8'h00);
      add(3'b100, 8'h03, 3, 2'b00, 8'h00);
      add(3'b100, 8'h04, 4, 2'b00, 8'h00);
      add(3'b100, 8'h99, 4, 2'b10, 8'h00);
      add(3'b010, 8'h00, 3, 2'b10, 8'h01);
      add(3'b010, 8'h00, 2, 2'b10, 8'h02);
      add(3'b010, 8'h00, 1, 2'b10, 8'h03);
      add(3'b010, 8'h00, 0, 2'b10, 8'h04);
      add(3'b010, 8'h00, 0, 2'b11, 8'h04);
      add(3'b000, 8'h00, 0, 2'b11, 8'h04);
      add(3'b111, 8'hAB, 0, 2'b00, 8'h00);
      add(3'b100, 8'hC3, 1, 2'b00, 8'h00);
      add(3'b010, 8'h00, 0, 2'b00, 8'hC3);

      step;
      step;
      c0("reset", 0, 0, 0, 8'h00);
      c1("reset", 0, 0, 0, 8'h00);
      rst = 1;

      for (int i = 0; i < tv.size(); i++) begin
         {w0, r0, f0} = tv[i].op;
         din0 = tv[i].din;
         step;
         c0($sformatf("row%0d", i), tv[i].cnt, tv[i].err[1], tv[i].err[0], tv[i].dout);
      end
      {w0, r0, f0} = 3'b000;

      // Flush at count=3 with a write and a pending underflow.
      r0 = 1;
      step;
      r0 = 0;
      for (int i = 0; i < 3; i++) begin
         w0 = 1;
         din0 = 8'hD0 + 8'(i);
         step;
      end
      c0("pre-flush", 3, 0, 1, 8'hC3);
      f0 = 1;
      din0 = 8'hEE;
      step;
      f0 = 0;
      w0 = 0;
      c0("flush mid", 0, 0, 0, 8'h00);

      // Same again with reset instead of flush.
      r0 = 1;
      step;
      r0 = 0;
      for (int i = 0; i < 3; i++) begin
         w0 = 1;
         din0 = 8'hE0 + 8'(i);
         step;
      end
      c0("pre-reset", 3, 0, 1, 8'h00);
      rst = 0;
      din0 = 8'hEF;
      step;
      rst = 1;
      w0 = 0;
      c0("reset mid", 0, 0, 0, 8'h00);
      w0 = 1;
      din0 = 8'hC3;
      step;
      w0 = 0;
      r0 = 1;
      step;
      r0 = 0;
      c0("after reset", 0, 0, 0, 8'hC3);

      // FWFT head visibility and pop.
      w1 = 1;
      din1 = 8'hA5;
      step;
      w1 = 0;
      c1("write", 1, 0, 0, 8'hA5);
      step;
      c1("hold", 1, 0, 0, 8'hA5);
      r1 = 1;
      step;
      r1 = 0;
      c1("pop", 0, 0, 0, 8'h00);

      // Random run: both instances share stimulus and one queue model.
      f0 = 1;
      f1 = 1;
      step;
      q.delete();
      dstd = 0;
      m_ov = 0;
      m_un = 0;
      for (int i = 0; i < 600; i++) begin
         int wp, rp;
         logic wr, rd, fl, fullm, emptym;
         logic [7:0] d;
         wp = (i / 60) % 2 ? 30 : 70;
         rp = 100 - wp;
         wr = $urandom_range(0, 99) < wp;
         rd = $urandom_range(0, 99) < rp;
         fl = $urandom_range(0, 99) < 2;
         d = 8'($urandom);
         {w0, r0, f0, din0} = {wr, rd, fl, d};
         {w1, r1, f1, din1} = {wr, rd, fl, d};
         fullm = q.size() == 4;
         emptym = q.size() == 0;
         if (fl) begin
            q.delete();
            m_ov = 0;
            m_un = 0;
            dstd = 0;
         end else begin
            m_ov |= wr && fullm;
            m_un |= rd && emptym;
            if (rd && !emptym) dstd = q.pop_front();
            if (wr && !fullm) q.push_back(d);
         end
         step;
         c0($sformatf("rnd%0d", i), q.size(), m_ov, m_un, dstd);
         c1($sformatf("rnd%0d", i), q.size(), m_ov, m_un, q.size() != 0 ? q[0] : 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous FIFO that succeeds the fixed 8-bit/4-deep single-mode FIFO used in the dataflow wrappers.
- Adds:
  - Configurable width and depth.
  - Selectable standard or first-word-fall-through (FWFT) read mode.
  - Programmable almost-full and almost-empty flags.
  - Occupancy count, synchronous flush, and sticky overflow/underflow error flags.
- Sits between dataflow actors as the standard inter-actor channel buffer.

Parameters:
- DATA_WIDTH, 8, bits per word (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- FWFT, 0, 0 = standard read (dout registered, 1-cycle latency); 1 = head word visible on dout while !empty
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous reset, active-low
- din  in  DATA_WIDTH  write data
- write  in  1  write request
- full  out  1  no free entries
- almost_full  out  1  count >= AF_THRESH
- dout  out  DATA_WIDTH  read data
- read  in  1  read request (FWFT=1: acknowledge/pop of head word)
- empty  out  1  no valid entries
- almost_empty  out  1  count <= AE_THRESH
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- flush  in  1  synchronous clear of contents
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst==0 at rising edge) values:
  - Pointers, count, dout, overflow and underflow all 0.
  - empty=1, full=0, almost_full=0, almost_empty=1.
  - Storage contents are not cleared.
  - Reset overrides all other inputs.
- Pointers and flags:
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes wrap.
  - full when the address bits are equal and the MSBs differ; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH with no special case at the DEPTH-1 -> 0 address transition.
- Accept rules, evaluated on registered state at the clock edge:
  - A write is accepted iff write && !full.
  - A read is accepted iff read && !empty.
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- count update: count_next = count + wr_acc - rd_acc. All flags are registered and derived from count_next, so they are valid the cycle after the causing edge.
- Standard mode (FWFT=0):
  - An accepted read loads mem[rd_addr] into dout at that edge; data is valid on dout the following cycle.
  - dout holds its value when there is no read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_addr] combinationally whenever !empty.
  - dout = 0 when empty.
  - read pops the current head.
  - First-write-to-dout latency is 1 cycle: written at edge N, visible after edge N.
- Errors:
  - write && full sets overflow; read && empty sets underflow.
  - Both flags stay set until reset or flush.
  - Rejected operations never modify pointers or storage.
- Flush:
  - Pointers, count, overflow and underflow go to 0; flags return to their reset values; dout goes to 0.
  - Flush has priority over a simultaneous read or write; both are ignored and do not set error flags.
- Reset or flush mid-stream discards all stored words. The first subsequent write lands at address 0.

Decomposition:
- Package fifo_pkg:
  - ptr_w(depth) and cnt_w(depth) functions.
  - Typedef fifo_mode_e {FIFO_STD, FIFO_FWFT}.
  - Elaboration check that DEPTH is a power of two and thresholds are in range.
- Sub-module fifo_ram (DATA_WIDTH, DEPTH):
  - Single write port, asynchronous read.
  - Inputs: clk, we, waddr, wdata, raddr; output rdata.
- fifo_flex holds the pointers, count, flags and the dout register/mux.

Test Plan:
- Reset/idle (DATA_WIDTH=8, DEPTH=4, FWFT=0): hold rst=0 for 2 cycles -> empty=1, full=0, count=0, almost_empty=1, dout=0x00, error flags 0.
- Fill/drain with wrap: write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1 after the 3rd write. Read 2, write 0x55,0x66, read 4 -> dout sequence 0x11..0x66 in order, empty=1 at end.
- Simultaneous read and write:
  - count=2, write 0x77 with read -> count stays 2, dout=oldest word next cycle.
  - When empty, write+read -> count=1, underflow=1.
- Overflow/underflow: full FIFO, write 0x99 -> overflow=1, contents unchanged, 0x99 never read. Empty FIFO, read -> underflow=1. Both hold until flush.
- FWFT=1: write 0xA5 -> dout=0xA5 the cycle after write with empty=0 and no read. Assert read -> empty=1, dout=0x00.
- Flush/reset mid-operation:
  - count=3, flush with write=1 -> count=0, empty=1, errors cleared, the write is discarded.
  - Repeat with rst=0 instead of flush -> same result.
  - Next write 0xC3 is read back as 0xC3.
